// File: rtl/debouncer_defs.sv
`default_nettype none
// ============================================================================
// debouncer_defs: shared state encoding and defaults for the button debouncer
// Revision: 1.0
// ============================================================================
package debouncer_defs;

  typedef enum logic [1:0] {
    REPOSO      = 2'b00,
    ESPERA_ALTO = 2'b01,
    PRESIONADO  = 2'b10,
    ESPERA_BAJO = 2'b11
  } estado_t;

  localparam int CICLOS_ESTABLES_DEF = 1000000;
  localparam int PROF_SYNC           = 2;

endpackage
`default_nettype wire

// File: rtl/debouncer_un_boton.sv
`default_nettype none
// ============================================================================
// debouncer_un_boton: synchroniser, debounce FSM and one-shot for one button
// Revision: 1.0
// ============================================================================
module debouncer_un_boton
  import debouncer_defs::*;
#(
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_boton,
  output logic o_pulso,
  output logic o_nivel
);

  localparam int ANCHO_CONTADOR = $clog2(CICLOS_ESTABLES);
  localparam logic [ANCHO_CONTADOR-1:0] CUENTA_FINAL = ANCHO_CONTADOR'(CICLOS_ESTABLES - 1);
  localparam logic [ANCHO_CONTADOR-1:0] UNO          = ANCHO_CONTADOR'(1);

  logic [PROF_SYNC-1:0]      sync;
  logic                      s;
  estado_t                   estado;
  logic [ANCHO_CONTADOR-1:0] contador;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[PROF_SYNC-2:0], i_boton};
    end
  end

  assign s = sync[PROF_SYNC-1];

  // Level only moves on the accepting transitions, so it is 1 exactly in
  // PRESIONADO and ESPERA_BAJO.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      estado   <= REPOSO;
      contador <= '0;
      o_pulso  <= 1'b0;
      o_nivel  <= 1'b0;
    end else begin
      o_pulso <= 1'b0;
      case (estado)
        REPOSO: begin
          if (s) begin
            estado   <= ESPERA_ALTO;
            contador <= '0;
          end
        end
        ESPERA_ALTO: begin
          if (!s) begin
            estado   <= REPOSO;
            contador <= '0;
          end else if (contador == CUENTA_FINAL) begin
            estado   <= PRESIONADO;
            contador <= '0;
            o_pulso  <= 1'b1;
            o_nivel  <= 1'b1;
          end else begin
            contador <= contador + UNO;
          end
        end
        PRESIONADO: begin
          if (!s) begin
            estado   <= ESPERA_BAJO;
            contador <= '0;
          end
        end
        ESPERA_BAJO: begin
          if (s) begin
            estado   <= PRESIONADO;
            contador <= '0;
          end else if (contador == CUENTA_FINAL) begin
            estado   <= REPOSO;
            contador <= '0;
            o_nivel  <= 1'b0;
          end else begin
            contador <= contador + UNO;
          end
        end
        default: begin
          estado   <= REPOSO;
          contador <= '0;
          o_nivel  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/debouncer_botones.sv
`default_nettype none
// ============================================================================
// debouncer_botones: independent debounce and press pulse for each button
// Revision: 1.0
// ============================================================================
module debouncer_botones
  import debouncer_defs::*;
#(
  parameter int CANT_BOTONES    = 4,
  parameter int CICLOS_ESTABLES = CICLOS_ESTABLES_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [CANT_BOTONES-1:0] i_botones,
  output logic [CANT_BOTONES-1:0] o_pulsos,
  output logic [CANT_BOTONES-1:0] o_niveles
);

  for (genvar i = 0; i < CANT_BOTONES; i++) begin : g_boton
    debouncer_un_boton #(
      .CICLOS_ESTABLES(CICLOS_ESTABLES)
    ) u_boton (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_boton (i_botones[i]),
      .o_pulso (o_pulsos[i]),
      .o_nivel (o_niveles[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_debouncer_botones.sv
`default_nettype none
// Bench for debouncer_botones: directed scenarios plus random bouncing
// inputs checked against a run-length model of the debounce rules.
module tb_debouncer_botones;

  localparam int N   = 4;
  localparam int C   = 4;
  // Observation index of the pulse when the sampling edge is counted as 1.
  localparam int LAT = C + 3;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic [N-1:0] botones = '0;
  logic [N-1:0] pulsos;
  logic [N-1:0] niveles;

  int compared   = 0;
  int mismatched = 0;

  debouncer_botones #(
    .CANT_BOTONES    (N),
    .CICLOS_ESTABLES (C)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_botones (botones),
    .o_pulsos  (pulsos),
    .o_niveles (niveles)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the synchronised input has disagreed with it on
  // C+1 consecutive edges; flipping to 1 is a press pulse.
  logic [N-1:0] m_s1, m_s2, exp_pulsos, exp_niveles;
  int           m_run [N];

  always @(posedge clk) begin
    if (rst) begin
      m_s1        <= '0;
      m_s2        <= '0;
      exp_pulsos  <= '0;
      exp_niveles <= '0;
      for (int i = 0; i < N; i++) m_run[i] <= 0;
    end else begin
      m_s1 <= botones;
      m_s2 <= m_s1;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] == exp_niveles[i]) begin
          m_run[i]      <= 0;
          exp_pulsos[i] <= 1'b0;
        end else if (m_run[i] == C) begin
          m_run[i]       <= 0;
          exp_niveles[i] <= m_s2[i];
          exp_pulsos[i]  <= m_s2[i];
        end else begin
          m_run[i]      <= m_run[i] + 1;
          exp_pulsos[i] <= 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst     = 1'b1;
    botones = '1;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if ({pulsos, niveles} !== '0) begin
        mismatched++;
        $display("FAIL reset_outputs: got pulsos=%b niveles=%b, want 0000/0000", pulsos, niveles);
      end
    end
    botones = '0;
    rst     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_press();
    int first = 0, npul = 0, bad_lvl = 0, other = 0;
    @(negedge clk);
    botones[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (pulsos[0]) begin
        npul++;
        if (first == 0) first = k;
      end
      if (pulsos[N-1:1] != '0) other++;
      if ((first != 0) != niveles[0]) bad_lvl++;
    end
    compared++;
    if (first !== LAT) begin
      mismatched++;
      $display("FAIL press_latency: got %0d, want %0d", first, LAT);
    end
    compared++;
    if (npul !== 1) begin
      mismatched++;
      $display("FAIL press_pulse_count: got %0d, want 1", npul);
    end
    compared++;
    if (bad_lvl !== 0) begin
      mismatched++;
      $display("FAIL press_level: got %0d bad cycles, want 0", bad_lvl);
    end
    compared++;
    if (other !== 0) begin
      mismatched++;
      $display("FAIL press_other_bits: got %0d cycles with pulses, want 0", other);
    end
  endtask

  task automatic test_bounce();
    bit [13:0] pat = 14'b00000000110111;
    int np = 0, lv = 0, np2 = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      botones[1] = pat[k];
      @(posedge clk); #1;
      if (pulsos[1])  np++;
      if (niveles[1]) lv++;
    end
    compared++;
    if (np !== 0 || lv !== 0) begin
      mismatched++;
      $display("FAIL bounce_reject: got pulses=%0d level_cycles=%0d, want 0/0", np, lv);
    end
    @(negedge clk);
    botones[1] = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (pulsos[1]) np2++;
    end
    compared++;
    if (np2 !== 1) begin
      mismatched++;
      $display("FAIL bounce_then_hold: got %0d pulses, want 1", np2);
    end
    @(negedge clk);
    botones[1] = 1'b0;
    repeat (10) @(negedge clk);
    compared++;
    if (niveles[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL bounce_release_level: got %b, want 0", niveles[1]);
    end
  endtask

  task automatic test_release_bounce();
    bit [2:0] pat = 3'b100;
    int early = 0, fall = 0, np = 0;
    compared++;
    if (niveles[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL release_pre_level: got %b, want 1", niveles[0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      botones[0] = pat[k];
      @(posedge clk); #1;
      if (!niveles[0]) early++;
      if (pulsos[0])   np++;
    end
    @(negedge clk);
    botones[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (!niveles[0] && fall == 0) fall = k;
      if (pulsos[0]) np++;
    end
    compared++;
    if (early !== 0) begin
      mismatched++;
      $display("FAIL release_bounce_level: got %0d low cycles, want 0", early);
    end
    compared++;
    if (fall !== LAT) begin
      mismatched++;
      $display("FAIL release_latency: got %0d, want %0d", fall, LAT);
    end
    compared++;
    if (np !== 0) begin
      mismatched++;
      $display("FAIL release_pulses: got %0d, want 0", np);
    end
  endtask

  task automatic test_simultaneous();
    int ncyc = 0;
    logic [N-1:0] seen = '0;
    compared++;
    if (niveles !== '0) begin
      mismatched++;
      $display("FAIL simul_idle: got %b, want 0000", niveles);
    end
    @(negedge clk);
    botones = 4'b1010;
    repeat (15) begin
      @(posedge clk); #1;
      if (pulsos != '0) begin
        ncyc++;
        seen = pulsos;
      end
    end
    compared++;
    if (ncyc !== 1 || seen !== 4'b1010) begin
      mismatched++;
      $display("FAIL simul_pulse: got %0d cycles last=%b, want 1 cycle 1010", ncyc, seen);
    end
    compared++;
    if (niveles !== 4'b1010) begin
      mismatched++;
      $display("FAIL simul_level: got %b, want 1010", niveles);
    end
    @(negedge clk);
    botones = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad = 0, np = 0, first = 0;
    @(negedge clk);
    botones[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (pulsos != '0 || niveles != '0) bad++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (pulsos[2]) begin
        np++;
        if (first == 0) first = k;
      end
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got %0d nonzero cycles, want 0", bad);
    end
    compared++;
    if (np !== 1 || first !== LAT) begin
      mismatched++;
      $display("FAIL reset_mid_repress: got %0d pulses at %0d, want 1 at %0d", np, first, LAT);
    end
    @(negedge clk);
    botones = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_on_pulse();
    bit found = 1'b0;
    @(negedge clk);
    botones[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (pulsos[3]) begin
        found = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL reset_on_pulse_timeout: got no pulse in 20 cycles, want one");
    end else if (pulsos !== '0 || niveles !== '0) begin
      mismatched++;
      $display("FAIL reset_on_pulse: got pulsos=%b niveles=%b, want 0000/0000", pulsos, niveles);
    end
    @(negedge clk);
    rst     = 1'b0;
    botones = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      compared++;
      if (pulsos !== exp_pulsos || niveles !== exp_niveles) begin
        mismatched++;
        $display("FAIL random_cycle_%0d: got pulsos=%b niveles=%b, want %b/%b",
                 k, pulsos, niveles, exp_pulsos, exp_niveles);
      end
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) botones[i] = ~botones[i];
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid();
    test_reset_on_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
